// File: rtl/mips32_pkg.sv
// Shared ISA definitions for the 5-stage MIPS32 core: opcodes, instruction classes, decode helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04;
  localparam logic [5:0] OP_MUL   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0A;
  localparam logic [5:0] OP_SUBI  = 6'h0B;
  localparam logic [5:0] OP_SLTI  = 6'h0C;
  localparam logic [5:0] OP_BNEQZ = 6'h0D;
  localparam logic [5:0] OP_BEQZ  = 6'h0E;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT} iclass_t;
  typedef enum logic [1:0] {FWD_NONE, FWD_EXMEM, FWD_MEMWB} fwd_t;

  // Unknown opcodes fall into HALT so a stray word stops the core cleanly.
  function automatic iclass_t decode_class(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                    return RM_ALU;
      OP_LW:                                        return LOAD;
      OP_SW:                                        return STORE;
      OP_BNEQZ, OP_BEQZ:                            return BRANCH;
      default:                                      return HALT;
    endcase
  endfunction

  function automatic logic [4:0] dest_field(input iclass_t cls, input logic [4:0] rt,
                                            input logic [4:0] rd);
    return (cls == RR_ALU) ? rd : rt;
  endfunction

  function automatic logic writes_reg(input iclass_t cls);
    return (cls == RR_ALU) || (cls == RM_ALU) || (cls == LOAD);
  endfunction

endpackage

// File: rtl/mips32_hazard_unit.sv
// Forwarding selects for EX operands, load-use interlock and branch flush control.
// Latency: purely combinational.
// Backpressure: stall holds PC and IF/ID for one cycle; a taken branch overrides the stall.
module mips32_hazard_unit
  import mips32_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          id_vld,
  input  iclass_t       id_cls,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          ex_vld,
  input  iclass_t       ex_cls,
  input  logic [RW-1:0] ex_rs,
  input  logic [RW-1:0] ex_rt,
  input  logic [RW-1:0] ex_dest,
  input  logic          mem_vld,
  input  logic          mem_we,
  input  iclass_t       mem_cls,
  input  logic [RW-1:0] mem_dest,
  input  logic          wb_vld,
  input  logic          wb_we,
  input  logic [RW-1:0] wb_dest,
  input  logic          br_taken,
  output fwd_t          fwd_a,
  output fwd_t          fwd_b,
  output logic          stall,
  output logic          flush
);

  logic mem_fwd_ok, wb_fwd_ok, load_use;

  // A load still in EX/MEM has no data yet; the interlock guarantees it is taken from MEM/WB.
  assign mem_fwd_ok = mem_vld && mem_we && (mem_dest != '0) && (mem_cls != LOAD);
  assign wb_fwd_ok  = wb_vld && wb_we && (wb_dest != '0);

  always_comb begin
    fwd_a = FWD_NONE;
    fwd_b = FWD_NONE;
    if (wb_fwd_ok && (wb_dest == ex_rs))   fwd_a = FWD_MEMWB;
    if (mem_fwd_ok && (mem_dest == ex_rs)) fwd_a = FWD_EXMEM;
    if (wb_fwd_ok && (wb_dest == ex_rt))   fwd_b = FWD_MEMWB;
    if (mem_fwd_ok && (mem_dest == ex_rt)) fwd_b = FWD_EXMEM;
  end

  assign load_use = ex_vld && (ex_cls == LOAD) && id_vld &&
                    ((ex_dest == id_rs) ||
                     ((ex_dest == id_rt) && ((id_cls == RR_ALU) || (id_cls == STORE))));

  assign flush = br_taken;
  assign stall = load_use && !br_taken;

endmodule

// File: rtl/mips32_pipe_core_v2.sv
// Single-clock 5-stage MIPS32 core with EX forwarding, load-use interlock and branch flush.
// Latency: one instr/cycle without hazards, writeback 4 cycles after fetch; 1 load-use, 2 taken-branch bubbles.
// Backpressure: none external; memories are combinational-read, HLT freezes the core until reset.
module mips32_pipe_core_v2
  import mips32_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int IADDR_W = 10,
  parameter int DADDR_W = 10,
  parameter int NREGS   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  output logic               dmem_we,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               halted,
  output logic [31:0]        instret,
  input  logic [4:0]         dbg_raddr,
  output logic [XLEN-1:0]    dbg_rdata
);

  localparam int RW = $clog2(NREGS);

  typedef struct packed {
    logic               vld;
    logic [31:0]        ir;
    logic [IADDR_W-1:0] npc;
  } if_id_t;

  typedef struct packed {
    logic               vld;
    iclass_t            cls;
    logic [5:0]         op;
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic [XLEN-1:0]    imm;
    logic [RW-1:0]      rs;
    logic [RW-1:0]      rt;
    logic [RW-1:0]      dest;
    logic               we;
    logic [IADDR_W-1:0] npc;
  } id_ex_t;

  typedef struct packed {
    logic            vld;
    iclass_t         cls;
    logic            we;
    logic [RW-1:0]   dest;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] b;
  } ex_mem_t;

  typedef struct packed {
    logic            vld;
    iclass_t         cls;
    logic            we;
    logic [RW-1:0]   dest;
    logic [XLEN-1:0] res;
  } mem_wb_t;

  logic [IADDR_W-1:0] pc;
  logic               fetch_stop;
  if_id_t             if_id;
  id_ex_t             id_ex;
  ex_mem_t            ex_mem;
  mem_wb_t            mem_wb;
  logic [XLEN-1:0]    regs [NREGS];

  // ID stage
  logic [5:0]      id_op;
  iclass_t         id_cls;
  logic [RW-1:0]   id_rs, id_rt, id_dest;
  logic [4:0]      id_dest5;
  logic [XLEN-1:0] id_a, id_b, id_imm;
  logic            id_halt, wb_we;

  assign id_op    = if_id.ir[31:26];
  assign id_cls   = decode_class(id_op);
  assign id_rs    = if_id.ir[21 +: RW];
  assign id_rt    = if_id.ir[16 +: RW];
  assign id_dest5 = dest_field(id_cls, if_id.ir[20:16], if_id.ir[15:11]);
  assign id_dest  = id_dest5[RW-1:0];
  assign id_imm   = XLEN'($signed(if_id.ir[15:0]));
  assign id_halt  = if_id.vld && (id_cls == HALT);

  // Write-through so an ID read of the register being written this cycle sees the new value.
  assign wb_we = mem_wb.vld && mem_wb.we && (mem_wb.dest != '0) && !halted;
  assign id_a  = (wb_we && (mem_wb.dest == id_rs)) ? mem_wb.res : regs[id_rs];
  assign id_b  = (wb_we && (mem_wb.dest == id_rt)) ? mem_wb.res : regs[id_rt];

  // EX stage
  fwd_t               fwd_a, fwd_b;
  logic               stall, flush, br_taken;
  logic [XLEN-1:0]    ex_a, ex_b, ex_op2, alu_res;
  logic [IADDR_W-1:0] br_target;

  mips32_hazard_unit #(.RW(RW)) u_hazard (
    .id_vld   (if_id.vld),
    .id_cls   (id_cls),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .ex_vld   (id_ex.vld),
    .ex_cls   (id_ex.cls),
    .ex_rs    (id_ex.rs),
    .ex_rt    (id_ex.rt),
    .ex_dest  (id_ex.dest),
    .mem_vld  (ex_mem.vld),
    .mem_we   (ex_mem.we),
    .mem_cls  (ex_mem.cls),
    .mem_dest (ex_mem.dest),
    .wb_vld   (mem_wb.vld),
    .wb_we    (mem_wb.we),
    .wb_dest  (mem_wb.dest),
    .br_taken (br_taken),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b),
    .stall    (stall),
    .flush    (flush)
  );

  always_comb begin
    case (fwd_a)
      FWD_EXMEM: ex_a = ex_mem.alu;
      FWD_MEMWB: ex_a = mem_wb.res;
      default:   ex_a = id_ex.a;
    endcase
    case (fwd_b)
      FWD_EXMEM: ex_b = ex_mem.alu;
      FWD_MEMWB: ex_b = mem_wb.res;
      default:   ex_b = id_ex.b;
    endcase
  end

  assign ex_op2 = (id_ex.cls == RR_ALU) ? ex_b : id_ex.imm;

  always_comb begin
    case (id_ex.op)
      OP_SUB, OP_SUBI: alu_res = ex_a - ex_op2;
      OP_AND:          alu_res = ex_a & ex_op2;
      OP_OR:           alu_res = ex_a | ex_op2;
      OP_SLT, OP_SLTI: alu_res = XLEN'($signed(ex_a) < $signed(ex_op2));
      OP_MUL:          alu_res = ex_a * ex_op2;
      default:         alu_res = ex_a + ex_op2;
    endcase
  end

  assign br_taken  = id_ex.vld && (id_ex.cls == BRANCH) &&
                     ((id_ex.op == OP_BEQZ) == (ex_a == '0));
  assign br_target = id_ex.npc + id_ex.imm[IADDR_W-1:0];

  // MEM stage; rst_n gating keeps a store caught in flight by reset from landing.
  assign dmem_addr  = ex_mem.alu[DADDR_W-1:0];
  assign dmem_wdata = ex_mem.b;
  assign dmem_we    = rst_n && !halted && ex_mem.vld && (ex_mem.cls == STORE);
  assign imem_addr  = pc;
  assign dbg_rdata  = regs[dbg_raddr[RW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= '0;
      fetch_stop <= 1'b0;
      if_id      <= '0;
      id_ex      <= '0;
      ex_mem     <= '0;
      mem_wb     <= '0;
      halted     <= 1'b0;
      instret    <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (!halted) begin
      if (wb_we) regs[mem_wb.dest] <= mem_wb.res;
      if (mem_wb.vld) begin
        instret <= instret + 32'd1;
        if (mem_wb.cls == HALT) halted <= 1'b1;
      end

      mem_wb <= '{vld: ex_mem.vld, cls: ex_mem.cls, we: ex_mem.we, dest: ex_mem.dest,
                  res: (ex_mem.cls == LOAD) ? dmem_rdata : ex_mem.alu};
      ex_mem <= '{vld: id_ex.vld, cls: id_ex.cls, we: id_ex.we, dest: id_ex.dest,
                  alu: alu_res, b: ex_b};

      if (flush) begin
        pc        <= br_target;
        if_id.vld <= 1'b0;
        id_ex.vld <= 1'b0;
      end else if (stall) begin
        id_ex.vld <= 1'b0;
      end else begin
        id_ex <= '{vld: if_id.vld, cls: id_cls, op: id_op, a: id_a, b: id_b, imm: id_imm,
                   rs: id_rs, rt: id_rt, dest: id_dest, we: writes_reg(id_cls),
                   npc: if_id.npc};
        // Once HLT leaves ID nothing younger can ever retire, so fetch stops for good.
        if (id_halt) fetch_stop <= 1'b1;
        if (fetch_stop || id_halt) begin
          if_id.vld <= 1'b0;
        end else begin
          pc    <= pc + IADDR_W'(1);
          if_id <= '{vld: 1'b1, ir: imem_rdata, npc: pc + IADDR_W'(1)};
        end
      end
    end
  end

endmodule

// File: tb/tb_mips32_pipe_core_v2.sv
// Directed-program bench for mips32_pipe_core_v2: runs small programs to HLT and checks regs, counters, timing.
module tb_mips32_pipe_core_v2;

  localparam logic [5:0] T_ADD = 6'h00, T_SUB = 6'h01, T_LW = 6'h08, T_SW = 6'h09;
  localparam logic [5:0] T_ADDI = 6'h0A, T_SUBI = 6'h0B, T_BNEQZ = 6'h0D;
  localparam logic [31:0] HLT_W = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  imem_addr, dmem_addr;
  logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, instret, dbg_rdata;
  logic        dmem_we, halted;
  logic [4:0]  dbg_raddr = 5'd0;

  logic [31:0] imem [1024];
  logic [31:0] dmem [1024];
  int store_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  mips32_pipe_core_v2 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata),
    .halted     (halted),
    .instret    (instret),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    if (dmem_we) begin
      dmem[dmem_addr] <= dmem_wdata;
      store_cnt <= store_cnt + 1;
    end
  end

  function automatic logic [31:0] rr(input logic [5:0] op, input int rs, input int rt, input int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) imem[i] = HLT_W;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(output int cyc);
    cyc = 0;
    while (!halted && cyc < 300) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic load_loop_prog();
    clear_imem();
    imem[0] = ri(T_ADDI, 0, 1, 3);
    imem[1] = ri(T_SUBI, 1, 1, 1);
    imem[2] = ri(T_BNEQZ, 1, 0, -2);
    imem[3] = ri(T_ADDI, 7, 7, 1);
    imem[4] = HLT_W;
  endtask

  task automatic test_reset();
    clear_imem();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (imem_addr !== 10'd0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", imem_addr); end
    n_checks++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b expected 0", halted); end
    n_checks++;
    if (instret !== 32'd0) begin n_fail++; $display("FAIL reset_instret: got %0d expected 0", instret); end
    n_checks++;
    if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL reset_dmem_we: got %0b expected 0", dmem_we); end
  endtask

  task automatic test_basic();
    int cyc;
    int ridx[3] = '{1, 2, 3};
    logic [31:0] rexp[3] = '{32'd10, 32'd20, 32'd30};
    clear_imem();
    imem[0] = ri(T_ADDI, 0, 1, 10);
    imem[1] = ri(T_ADDI, 0, 2, 20);
    imem[2] = rr(T_ADD, 1, 2, 3);
    imem[3] = HLT_W;
    apply_reset();
    run_to_halt(cyc);
    n_checks++;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL basic_halted: got %0b expected 1 (timeout)", halted); end
    n_checks++;
    if (cyc != 8) begin n_fail++; $display("FAIL basic_cycles: got %0d expected 8", cyc); end
    n_checks++;
    if (instret !== 32'd4) begin n_fail++; $display("FAIL basic_instret: got %0d expected 4", instret); end
    for (int i = 0; i < 3; i++) begin
      dbg_raddr = 5'(ridx[i]);
      #1;
      n_checks++;
      if (dbg_rdata !== rexp[i]) begin
        n_fail++;
        $display("FAIL basic_R%0d: got %0d expected %0d", ridx[i], dbg_rdata, rexp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int ridx[3] = '{1, 2, 3};
    logic [31:0] rexp[3] = '{32'd5, 32'd10, 32'd5};
    clear_imem();
    imem[0] = ri(T_ADDI, 0, 1, 5);
    imem[1] = rr(T_ADD, 1, 1, 2);
    imem[2] = rr(T_SUB, 2, 1, 3);
    imem[3] = HLT_W;
    apply_reset();
    run_to_halt(cyc);
    n_checks++;
    if (cyc != 8 || halted !== 1'b1) begin
      n_fail++; $display("FAIL b2b_cycles: got %0d (halted %0b) expected 8", cyc, halted);
    end
    for (int i = 0; i < 3; i++) begin
      dbg_raddr = 5'(ridx[i]);
      #1;
      n_checks++;
      if (dbg_rdata !== rexp[i]) begin
        n_fail++;
        $display("FAIL b2b_R%0d: got %0d expected %0d", ridx[i], dbg_rdata, rexp[i]);
      end
    end
  endtask

  task automatic test_load_use();
    int cyc;
    int base;
    int ridx[2] = '{4, 5};
    logic [31:0] rexp[2] = '{32'd7, 32'd14};
    clear_imem();
    imem[0] = ri(T_ADDI, 0, 1, 7);
    imem[1] = ri(T_SW, 0, 1, 100);
    imem[2] = ri(T_LW, 0, 4, 100);
    imem[3] = rr(T_ADD, 4, 4, 5);
    imem[4] = HLT_W;
    apply_reset();
    base = store_cnt;
    run_to_halt(cyc);
    n_checks++;
    if (cyc != 10 || halted !== 1'b1) begin
      n_fail++; $display("FAIL lu_cycles: got %0d (halted %0b) expected 10", cyc, halted);
    end
    n_checks++;
    if (store_cnt - base != 1) begin n_fail++; $display("FAIL lu_stores: got %0d expected 1", store_cnt - base); end
    n_checks++;
    if (dmem[100] !== 32'd7) begin n_fail++; $display("FAIL lu_dmem100: got %0d expected 7", dmem[100]); end
    n_checks++;
    if (instret !== 32'd5) begin n_fail++; $display("FAIL lu_instret: got %0d expected 5", instret); end
    for (int i = 0; i < 2; i++) begin
      dbg_raddr = 5'(ridx[i]);
      #1;
      n_checks++;
      if (dbg_rdata !== rexp[i]) begin
        n_fail++;
        $display("FAIL lu_R%0d: got %0d expected %0d", ridx[i], dbg_rdata, rexp[i]);
      end
    end
  endtask

  task automatic test_branch_loop();
    int cyc;
    load_loop_prog();
    apply_reset();
    run_to_halt(cyc);
    n_checks++;
    if (cyc != 17 || halted !== 1'b1) begin
      n_fail++; $display("FAIL loop_cycles: got %0d (halted %0b) expected 17", cyc, halted);
    end
    n_checks++;
    if (instret !== 32'd9) begin n_fail++; $display("FAIL loop_instret: got %0d expected 9", instret); end
    dbg_raddr = 5'd1;
    #1;
    n_checks++;
    if (dbg_rdata !== 32'd0) begin n_fail++; $display("FAIL loop_R1: got %0d expected 0", dbg_rdata); end
    dbg_raddr = 5'd7;
    #1;
    n_checks++;
    if (dbg_rdata !== 32'd1) begin n_fail++; $display("FAIL loop_R7_squash: got %0d expected 1", dbg_rdata); end
  endtask

  task automatic test_r0_illegal();
    int cyc;
    int ridx[3] = '{0, 6, 8};
    logic [31:0] pc_at_halt;
    clear_imem();
    imem[0] = ri(T_ADDI, 0, 6, 4);
    imem[1] = ri(T_ADDI, 0, 0, 9);
    imem[2] = rr(T_ADD, 0, 0, 6);
    imem[3] = 32'h8000_0000;
    imem[4] = ri(T_ADDI, 0, 8, 1);
    imem[5] = HLT_W;
    apply_reset();
    run_to_halt(cyc);
    n_checks++;
    if (cyc != 8 || halted !== 1'b1) begin
      n_fail++; $display("FAIL illegal_cycles: got %0d (halted %0b) expected 8", cyc, halted);
    end
    n_checks++;
    if (instret !== 32'd4) begin n_fail++; $display("FAIL illegal_instret: got %0d expected 4", instret); end
    for (int i = 0; i < 3; i++) begin
      dbg_raddr = 5'(ridx[i]);
      #1;
      n_checks++;
      if (dbg_rdata !== 32'd0) begin
        n_fail++;
        $display("FAIL r0_R%0d: got %0d expected 0", ridx[i], dbg_rdata);
      end
    end
    pc_at_halt = 32'(imem_addr);
    repeat (5) @(negedge clk);
    n_checks++;
    if (instret !== 32'd4 || halted !== 1'b1 || 32'(imem_addr) !== pc_at_halt) begin
      n_fail++;
      $display("FAIL halt_frozen: instret %0d halted %0b pc %0d, expected 4 1 %0d",
               instret, halted, imem_addr, pc_at_halt);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    load_loop_prog();
    apply_reset();
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (imem_addr !== 10'd0 || halted !== 1'b0 || instret !== 32'd0 || dmem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_state: pc %0d halted %0b instret %0d we %0b expected 0 0 0 0",
               imem_addr, halted, instret, dmem_we);
    end
    dbg_raddr = 5'd1;
    #1;
    n_checks++;
    if (dbg_rdata !== 32'd0) begin n_fail++; $display("FAIL midrst_R1: got %0d expected 0", dbg_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    run_to_halt(cyc);
    n_checks++;
    if (cyc != 17 || halted !== 1'b1 || instret !== 32'd9) begin
      n_fail++;
      $display("FAIL midrst_rerun: cycles %0d halted %0b instret %0d expected 17 1 9", cyc, halted, instret);
    end
    dbg_raddr = 5'd7;
    #1;
    n_checks++;
    if (dbg_rdata !== 32'd1) begin n_fail++; $display("FAIL midrst_R7: got %0d expected 1", dbg_rdata); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_load_use();
    test_branch_loop();
    test_r0_illegal();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
